// File: rtl/perceptron_learn_pkg.sv
// Shared definitions for the serial-MAC perceptron: FSM encoding, accumulator
// sizing and weight saturation limits.
package perceptron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_RESULT = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  // Wide enough for N_IN full-scale weights plus a bias term without overflow.
  function automatic int acc_width(input int w_width, input int n_in);
    return w_width + $clog2(n_in + 1) + 1;
  endfunction

  function automatic int w_max(input int w_width);
    return (1 << (w_width - 1)) - 1;
  endfunction

  function automatic int w_min(input int w_width);
    return -(1 << (w_width - 1));
  endfunction

endpackage

// File: rtl/perceptron_learn_if.sv
// Sample, weight-write and result signals of the perceptron grouped as one bus.
interface perceptron_learn_if
  import perceptron_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int W_WIDTH   = 4,
  parameter int ERR_WIDTH = 8
);
  localparam int ADDR_W = $clog2(N_IN + 1);
  localparam int ACC_W  = acc_width(W_WIDTH, N_IN);

  logic                        in_valid;
  logic                        in_ready;
  logic [N_IN-1:0]             x_in;
  logic                        train;
  logic                        target;
  logic                        wr_en;
  logic [ADDR_W-1:0]           wr_addr;
  logic signed [W_WIDTH-1:0]   wr_data;
  logic                        out_valid;
  logic                        v_out;
  logic signed [ACC_W-1:0]     acc_out;
  logic [1:0]                  state_o;
  logic [ERR_WIDTH-1:0]        err_count;

  modport master (
    output in_valid, x_in, train, target, wr_en, wr_addr, wr_data,
    input  in_ready, out_valid, v_out, acc_out, state_o, err_count
  );

  modport slave (
    input  in_valid, x_in, train, target, wr_en, wr_addr, wr_data,
    output in_ready, out_valid, v_out, acc_out, state_o, err_count
  );

endinterface

// File: rtl/perceptron_learn_sat_step.sv
// Combinational signed +1/-1 step that sticks at the two's-complement limits.
module sat_step
  import perceptron_pkg::*;
#(
  parameter int W_WIDTH = 4
) (
  input  logic signed [W_WIDTH-1:0] value,
  input  logic                      up,
  output logic signed [W_WIDTH-1:0] result
);
  localparam logic signed [W_WIDTH-1:0] MAXV = W_WIDTH'(w_max(W_WIDTH));
  localparam logic signed [W_WIDTH-1:0] MINV = W_WIDTH'(w_min(W_WIDTH));

  always_comb begin
    result = value;
    if (up) begin
      if (value != MAXV) result = value + 1'b1;
    end else begin
      if (value != MINV) result = value - 1'b1;
    end
  end

endmodule

// File: rtl/perceptron_learn.sv
// Serial-MAC perceptron with perceptron-rule training. Define PERCEPTRON_BIAS_EN
// to add a trainable bias register written at weight index N_IN.
module perceptron_learn
  import perceptron_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int W_WIDTH   = 4,
  parameter int THRESH    = 2,
  parameter int ERR_WIDTH = 8
) (
  input logic               clk,
  input logic               reset_n,
  perceptron_learn_if.slave bus
);
  localparam int ACC_W  = acc_width(W_WIDTH, N_IN);
  localparam int ADDR_W = $clog2(N_IN + 1);
  localparam int IDX_W  = $clog2(N_IN);
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] THRESH_A = ACC_W'(THRESH);
  localparam logic [ERR_WIDTH-1:0]    ERR_MAX  = '1;

  state_t                    state, state_next;
  logic [IDX_W-1:0]          idx;
  logic signed [ACC_W-1:0]   acc, acc_next, term, acc_init;
  logic [N_IN-1:0]           x_lat;
  logic                      train_lat, target_lat;
  logic signed [W_WIDTH-1:0] w      [N_IN];
  logic signed [W_WIDTH-1:0] w_step [N_IN];
  logic                      v_out_r;
  logic signed [ACC_W-1:0]   acc_out_r;
  logic [ERR_WIDTH-1:0]      err_r;
  logic                      last, wr_ok;

  assign last  = (idx == LAST_IDX);
  assign wr_ok = (state == ST_IDLE) && bus.wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (bus.in_valid) state_next = ST_ACCUM;
      ST_ACCUM:  if (last) state_next = ST_RESULT;
      ST_RESULT: state_next = (train_lat && (v_out_r != target_lat)) ? ST_UPDATE : ST_IDLE;
      ST_UPDATE: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    term = '0;
    if (x_lat[idx]) term = ACC_W'(w[idx]);
    acc_next = acc + term;
  end

  // The result registers load on the last ACCUM edge so they are valid in RESULT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx        <= '0;
      acc        <= '0;
      x_lat      <= '0;
      train_lat  <= 1'b0;
      target_lat <= 1'b0;
      v_out_r    <= 1'b0;
      acc_out_r  <= '0;
      err_r      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            x_lat      <= bus.x_in;
            train_lat  <= bus.train;
            target_lat <= bus.target;
            acc        <= acc_init;
            idx        <= '0;
          end
        end
        ST_ACCUM: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (last) begin
            acc_out_r <= acc_next;
            v_out_r   <= (acc_next >= THRESH_A);
          end
        end
        ST_UPDATE: begin
          if (err_r != ERR_MAX) err_r <= err_r + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_step
    sat_step #(.W_WIDTH(W_WIDTH)) u_step (
      .value  (w[i]),
      .up     (target_lat),
      .result (w_step[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_IN; i++) w[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (wr_ok && bus.wr_addr == ADDR_W'(i)) w[i] <= bus.wr_data;
        else if (state == ST_UPDATE && x_lat[i]) w[i] <= w_step[i];
      end
    end
  end

`ifdef PERCEPTRON_BIAS_EN
  logic signed [W_WIDTH-1:0] bias, bias_step;

  sat_step #(.W_WIDTH(W_WIDTH)) u_bias_step (
    .value  (bias),
    .up     (target_lat),
    .result (bias_step)
  );

  // The bias behaves like a weight whose input is permanently 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bias <= '0;
    else if (wr_ok && bus.wr_addr == ADDR_W'(N_IN)) bias <= bus.wr_data;
    else if (state == ST_UPDATE) bias <= bias_step;
  end

  assign acc_init = ACC_W'(bias);
`else
  assign acc_init = '0;
`endif

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_RESULT);
  assign bus.v_out     = v_out_r;
  assign bus.acc_out   = acc_out_r;
  assign bus.state_o   = state;
  assign bus.err_count = err_r;

endmodule

// File: tb/tb_perceptron_learn.sv
// Self-checking bench for perceptron_learn: directed and random samples scored
// against an arithmetic perceptron model; a second instance uses THRESH=-10.
module tb_perceptron_learn;
  localparam int N_IN      = 4;
  localparam int W_WIDTH   = 4;
  localparam int ERR_WIDTH = 8;
  localparam int THRESH    = 2;
  localparam int THRESH2   = -10;
  localparam int ADDR_W    = $clog2(N_IN + 1);
  localparam int WMAX      = (1 << (W_WIDTH - 1)) - 1;
  localparam int WMIN      = -(1 << (W_WIDTH - 1));

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int passed = 0;
  int failed = 0;

  int mw [N_IN];
  int mbias;
  int merr;

  perceptron_learn_if #(.N_IN(N_IN), .W_WIDTH(W_WIDTH), .ERR_WIDTH(ERR_WIDTH)) b ();
  perceptron_learn_if #(.N_IN(N_IN), .W_WIDTH(W_WIDTH), .ERR_WIDTH(ERR_WIDTH)) b2 ();

  perceptron_learn #(.N_IN(N_IN), .W_WIDTH(W_WIDTH), .THRESH(THRESH), .ERR_WIDTH(ERR_WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(b)
  );

  perceptron_learn #(.N_IN(N_IN), .W_WIDTH(W_WIDTH), .THRESH(THRESH2), .ERR_WIDTH(ERR_WIDTH)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(b2)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_w(input int v);
    if (v > WMAX) return WMAX;
    if (v < WMIN) return WMIN;
    return v;
  endfunction

  function automatic int model_acc(input logic [N_IN-1:0] x);
    int s;
    s = mbias;
    for (int i = 0; i < N_IN; i++) if (x[i]) s += mw[i];
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_IN; i++) mw[i] = 0;
    mbias = 0;
    merr  = 0;
  endtask

  task automatic model_train(input logic [N_IN-1:0] x, input logic tg);
    int d;
    d = tg ? 1 : -1;
    for (int i = 0; i < N_IN; i++) if (x[i]) mw[i] = clamp_w(mw[i] + d);
`ifdef PERCEPTRON_BIAS_EN
    mbias = clamp_w(mbias + d);
`endif
    if (merr < (1 << ERR_WIDTH) - 1) merr++;
  endtask

  task automatic model_write(input int addr, input int data);
    if (addr < N_IN) mw[addr] = data;
`ifdef PERCEPTRON_BIAS_EN
    else if (addr == N_IN) mbias = data;
`endif
  endtask

  task automatic write_weight(input int addr, input int data);
    @(negedge clk);
    b.wr_en   = 1'b1;
    b.wr_addr = ADDR_W'(addr);
    b.wr_data = W_WIDTH'(data);
    @(negedge clk);
    b.wr_en = 1'b0;
    model_write(addr, data);
  endtask

  // One full transaction on the main instance, optionally with a weight write
  // on the accept edge; checks latency, result, ready return and error count.
  task automatic apply_stimulus(input logic [N_IN-1:0] x, input logic tr, input logic tg, input string tag,
                                input bit wr = 1'b0, input int wa = 0, input int wd = 0);
    int n;
    int exp_acc;
    logic exp_v;
    logic exp_upd;
    n = 0;
    @(negedge clk);
    while (b.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, ".ready_in"}, b.in_ready, 1);
    if (wr) begin
      b.wr_en   = 1'b1;
      b.wr_addr = ADDR_W'(wa);
      b.wr_data = W_WIDTH'(wd);
      model_write(wa, wd);
    end
    exp_acc = model_acc(x);
    exp_v   = (exp_acc >= THRESH);
    exp_upd = tr && (exp_v != tg);
    b.in_valid = 1'b1;
    b.x_in     = x;
    b.train    = tr;
    b.target   = tg;
    @(negedge clk);
    b.in_valid = 1'b0;
    b.wr_en    = 1'b0;
    n = 1;
    while (b.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, ".latency"}, n, N_IN + 1);
    check_output({tag, ".acc_out"}, b.acc_out, exp_acc);
    check_output({tag, ".v_out"}, b.v_out, exp_v);
    if (exp_upd) model_train(x, tg);
    @(negedge clk);
    check_output({tag, ".state_after"}, b.state_o, exp_upd ? 3 : 0);
    if (exp_upd) @(negedge clk);
    check_output({tag, ".ready_back"}, b.in_ready, 1);
    check_output({tag, ".err_count"}, b.err_count, merr);
  endtask

  task automatic dut2_sample(input logic [N_IN-1:0] x, input logic tr, input logic tg, output int lat);
    @(negedge clk);
    b2.in_valid = 1'b1;
    b2.x_in     = x;
    b2.train    = tr;
    b2.target   = tg;
    @(negedge clk);
    b2.in_valid = 1'b0;
    lat = 1;
    while (b2.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bad;
    int rx, rt, rg, ra, rd;
    logic [N_IN-1:0] hx;

    b.in_valid = 0; b.x_in = '0; b.train = 0; b.target = 0;
    b.wr_en = 0; b.wr_addr = '0; b.wr_data = '0;
    b2.in_valid = 0; b2.x_in = '0; b2.train = 0; b2.target = 0;
    b2.wr_en = 0; b2.wr_addr = '0; b2.wr_data = '0;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset.state", b.state_o, 0);
    check_output("reset.in_ready", b.in_ready, 1);
    check_output("reset.out_valid", b.out_valid, 0);
    check_output("reset.v_out", b.v_out, 0);
    check_output("reset.acc_out", b.acc_out, 0);
    check_output("reset.err_count", b.err_count, 0);
    reset_n = 1'b1;

    apply_stimulus(4'b1111, 1'b0, 1'b0, "basic");

    write_weight(0, 3);
    write_weight(1, -2);
    write_weight(3, 1);
    apply_stimulus(4'b1011, 1'b0, 1'b0, "sum_pos");
    apply_stimulus(4'b0010, 1'b0, 1'b0, "sum_neg");

    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    apply_stimulus(4'b0011, 1'b1, 1'b1, "train1");
    apply_stimulus(4'b0011, 1'b1, 1'b1, "train2");

    write_weight(0, -8);
    write_weight(2, 7);
    apply_stimulus(4'b0101, 1'b1, 1'b1, "sat_hi");
    apply_stimulus(4'b0100, 1'b0, 1'b0, "sat_hi_probe");

    apply_stimulus(4'b0100, 1'b0, 1'b0, "wr_and_accept", 1'b1, 2, -5);

    write_weight(7, 3);
    write_weight(N_IN, 2);
    apply_stimulus(4'b1111, 1'b0, 1'b0, "bad_addr");

    // A write strobe during ACCUM must not reach the weight file.
    write_weight(0, -3);
    @(negedge clk);
    b.in_valid = 1'b1; b.x_in = 4'b0001; b.train = 1'b0;
    @(negedge clk);
    b.in_valid = 1'b0;
    b.wr_en = 1'b1; b.wr_addr = '0; b.wr_data = 4'sd5;
    @(negedge clk);
    b.wr_en = 1'b0;
    lat = 2;
    while (b.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_output("wr_busy.latency", lat, N_IN + 1);
    apply_stimulus(4'b0001, 1'b0, 1'b0, "wr_busy_probe");

    // Continuous in_valid: accept on every IDLE cycle, in_ready low N_IN+1 cycles.
    hx = 4'b0110;
    @(negedge clk);
    b.in_valid = 1'b1; b.x_in = hx; b.train = 1'b0; b.target = 1'b0;
    bad = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (b.in_ready !== ((k % 6) == 0)) bad++;
      if (b.out_valid !== ((k % 6) == 5)) bad++;
      if (k == 17) b.in_valid = 1'b0;
    end
    check_output("handshake.pattern_errors", bad, 0);
    check_output("handshake.acc_out", b.acc_out, model_acc(hx));

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        ra = int'($urandom_range(0, (1 << ADDR_W) - 1));
        rd = int'($urandom_range(0, 15)) - 8;
        write_weight(ra, rd);
      end
      rx = int'($urandom_range(0, 15));
      rt = int'($urandom_range(0, 1));
      rg = int'($urandom_range(0, 1));
      apply_stimulus(N_IN'(rx), rt[0], rg[0], "random");
    end

    // Reset in the second ACCUM cycle after learning non-zero weights.
    for (int i = 0; i < N_IN; i++) write_weight(i, 3);
    apply_stimulus(4'b1111, 1'b1, 1'b0, "pre_abort");
    @(negedge clk);
    b.in_valid = 1'b1; b.x_in = 4'b1111; b.train = 1'b0;
    @(negedge clk);
    b.in_valid = 1'b0;
    @(negedge clk);
    check_output("abort.in_accum", b.state_o, 1);
    reset_n = 1'b0;
    #1;
    check_output("abort.state", b.state_o, 0);
    check_output("abort.in_ready", b.in_ready, 1);
    check_output("abort.out_valid", b.out_valid, 0);
    check_output("abort.v_out", b.v_out, 0);
    check_output("abort.acc_out", b.acc_out, 0);
    check_output("abort.err_count", b.err_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    apply_stimulus(4'b1111, 1'b0, 1'b0, "after_abort");

    // Low-saturation on the THRESH=-10 instance.
    @(negedge clk);
    b2.wr_en = 1'b1; b2.wr_addr = '0; b2.wr_data = -4'sd8;
    @(negedge clk);
    b2.wr_en = 1'b0;
    dut2_sample(4'b0001, 1'b1, 1'b0, lat);
    check_output("sat_lo.latency", lat, N_IN + 1);
    check_output("sat_lo.acc_out", b2.acc_out, -8);
    check_output("sat_lo.v_out", b2.v_out, 1);
    @(negedge clk);
    check_output("sat_lo.state_update", b2.state_o, 3);
    @(negedge clk);
    check_output("sat_lo.err_count", b2.err_count, 1);
    dut2_sample(4'b0001, 1'b0, 1'b0, lat);
    check_output("sat_lo.probe_acc", b2.acc_out, -8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
